// File: rtl/synth_pkg.sv
// Shared types and constants for the sample fetch arbiter.
// Voice indices, masks and the fetch controller state encoding.
package synth_pkg;

    localparam int NUM_VOICES = 4;
    localparam int SAMPLE_W   = 16;
    localparam int ADDR_W     = 16;

    typedef logic [1:0]            voice_idx_t;
    typedef logic [NUM_VOICES-1:0] voice_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RETURN
    } fetch_state_t;

    function automatic voice_mask_t voice_onehot(voice_idx_t i);
        return voice_mask_t'(1) << i;
    endfunction

endpackage

// File: rtl/sample_fetch_arbiter_if.sv
// Voice request / ROM bus bundle for the sample fetch arbiter.
// master is the arbiter side, slave is the voices plus ROM side.
interface sample_fetch_arbiter_if;
    import synth_pkg::*;

    voice_mask_t                       req;
    logic [NUM_VOICES-1:0][ADDR_W-1:0] req_addr;
    logic                              sample_tick;
    logic                              overrun_clr;
    logic [ADDR_W-1:0]                 Addr_out;
    voice_idx_t                        select_out;
    logic                              bus_en;
    logic [SAMPLE_W-1:0]               Data_in;
    logic [SAMPLE_W-1:0]               Data_out;
    voice_mask_t                       ack;
    logic                              overrun;

    modport master (
        input  req, req_addr, sample_tick, overrun_clr, Data_in,
        output Addr_out, select_out, bus_en, Data_out, ack, overrun
    );

    modport slave (
        output req, req_addr, sample_tick, overrun_clr, Data_in,
        input  Addr_out, select_out, bus_en, Data_out, ack, overrun
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first set request starting at ptr, wrapping.
// Purely combinational so it can be exercised on its own.
module rr_priority_pick
    import synth_pkg::*;
(
    input  voice_mask_t req,
    input  voice_idx_t  ptr,
    output logic        valid,
    output voice_idx_t  idx
);

    voice_mask_t rot;
    voice_idx_t  off;

    // Rotate so bit 0 is the voice at ptr, then take the lowest set bit.
    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            rot[i] = req[ptr + voice_idx_t'(i)];
        end
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = voice_idx_t'(i);
            end
        end
        valid = |rot;
        idx   = ptr + off;
    end

endmodule

// File: rtl/sample_fetch_arbiter.sv
// Shares one sample-ROM bus among four voices, round-robin.
// Holds the bus for the ROM latency, acks the sample, tracks overrun.
module sample_fetch_arbiter
    import synth_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input logic                   Clk,
    input logic                   Reset,
    sample_fetch_arbiter_if.master bus
);

    localparam logic [2:0] LAST = 3'(READ_LAT);

    fetch_state_t state;
    voice_idx_t   ptr;
    voice_idx_t   idx;
    logic [2:0]   cnt;
    voice_mask_t  pending;
    voice_mask_t  eff;
    logic         pick_valid;
    voice_idx_t   pick_idx;
    logic         tick_miss;

    assign eff = bus.req & ~bus.ack;

    rr_priority_pick u_pick (
        .req   (eff),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Fetch controller: grant, hold bus READ_LAT+1 cycles, ack one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            ptr            <= '0;
            idx            <= '0;
            cnt            <= '0;
            bus.Addr_out   <= '0;
            bus.select_out <= '0;
            bus.bus_en     <= 1'b0;
            bus.Data_out   <= '0;
            bus.ack        <= '0;
        end else begin
            bus.ack <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        idx            <= pick_idx;
                        bus.Addr_out   <= bus.req_addr[pick_idx];
                        bus.select_out <= pick_idx;
                        bus.bus_en     <= 1'b1;
                        cnt            <= '0;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        bus.Data_out   <= bus.Data_in;
                        bus.ack        <= voice_onehot(idx);
                        bus.bus_en     <= 1'b0;
                        bus.Addr_out   <= '0;
                        bus.select_out <= '0;
                        state          <= RETURN;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RETURN: begin
                    ptr   <= idx + voice_idx_t'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tick_miss = bus.sample_tick && (|(pending & ~bus.ack));

    // Per-period service tracking; an ack in the tick cycle counts as served.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pending     <= '0;
            bus.overrun <= 1'b0;
        end else begin
            if (bus.sample_tick) begin
                pending <= bus.req & ~bus.ack;
            end else begin
                pending <= pending & ~bus.ack;
            end
            if (tick_miss) begin
                bus.overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                bus.overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sample_fetch_arbiter.md
Name: sample_fetch_arbiter

Overview:
- Shares one 16-bit sample-ROM address bus among four voice requesters. Feeds the 4-way address demux: drives the address plus the 2-bit select, which picks the instrument ROM.
- Grants requests round-robin, holds the bus for the ROM read latency, captures the returned sample and hands it back with a one-cycle ack.
- Tracks whether every voice is served within one sample period; flags overrun otherwise.

Parameters:
- NUM_VOICES, 4, number of requesters; fixed at 4 to match the 2-bit select.
- READ_LAT, 1, synchronous ROM read latency in cycles (1..7).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- req  in  4  per-voice fetch request; level, held until that voice's ack
- req_addr  in  4x16  per-voice sample address; sampled only in the grant cycle
- sample_tick  in  1  one-cycle pulse at each audio sample period
- overrun_clr  in  1  clears the sticky overrun flag
- Addr_out  out  16  address to the demux
- select_out  out  2  demux select = granted voice index
- bus_en  out  1  high while Addr_out is meaningful
- Data_in  in  16  sample returned by the selected ROM
- Data_out  out  16  captured sample; valid only with ack
- ack  out  4  one-hot, one-cycle completion pulse
- overrun  out  1  sticky service-deadline miss

Behaviour:
- Reset (synchronous, highest priority, any state):
  - Addr_out=0, select_out=0, bus_en=0, Data_out=0, ack=0, overrun=0.
  - State=IDLE, round-robin pointer=0, pending mask=0.
  - An in-flight fetch is aborted and never acked.
- States: IDLE, BUSY, RETURN.
- IDLE:
  - Effective request = req masked by ack of the current cycle.
  - If nonzero, pick the first set bit searching ptr, ptr+1, ... mod 4. Register idx and the address (req_addr[idx]) and go to BUSY.
  - If zero, stay in IDLE.
- BUSY:
  - Lasts READ_LAT+1 cycles (counter).
  - Addr_out=latched address, select_out=idx, bus_en=1 for every BUSY cycle.
  - Data_in is captured into Data_out at the end of the last BUSY cycle. Go to RETURN.
- RETURN (one cycle):
  - ack[idx]=1; Data_out holds the sample; bus_en=0, Addr_out=0.
  - ptr <= idx+1 mod 4.
  - Next state = IDLE.
- RETURN-to-IDLE ordering: RETURN is a distinct cycle. IDLE in the cycle after RETURN evaluates req. The voice just acked must have dropped req by then; a still-high req is a new request.
- Timing with grant decided in IDLE cycle T:
  - Bus valid cycles T+1..T+1+READ_LAT.
  - ack in cycle T+2+READ_LAT.
  - Earliest next bus cycle is T+4+READ_LAT.
  - Throughput: one fetch per READ_LAT+3 cycles.
- Outside BUSY: Addr_out=0, select_out=0, so the demux routes zero to ROM 0; ROMs must qualify with bus_en.
- Data_out holds its last value between acks; consumers use it only with ack.
- req_addr changes after the grant cycle have no effect on the current fetch.
- Pending mask and overrun:
  - On sample_tick: if (pending & ~ack) != 0, set overrun. Then pending <= req & ~ack.
  - On any ack: clear that voice's pending bit.
  - sample_tick and ack in the same cycle: the ack wins for that voice, with no overrun for it.
  - overrun_clr clears overrun; if it coincides with a new overrun event, set wins.

Decomposition:
- Shared package (synth_pkg): NUM_VOICES, voice_idx_t (2-bit), fetch_state_t enum {IDLE, BUSY, RETURN}, SAMPLE_W=16.
- Sub-module rr_priority_pick: combinational; inputs 4-bit request and 2-bit pointer; outputs grant-valid and a 2-bit index. Unit-testable alone.
- Controller FSM, latency counter and overrun logic stay in the top module.

Test Plan:
- Single request, READ_LAT=1: req=0001, req_addr[0]=0x1234, ROM returns 0xBEEF. Expect:
  - Addr_out=0x1234, select_out=0, bus_en=1 for 2 cycles.
  - ack=0001 with Data_out=0xBEEF in the 3rd cycle after the grant.
- All four request continuously, each dropping req after its ack: grant order 0,1,2,3, then 0 on re-request. select_out follows that order; no voice is granted twice before the others.
- Pointer fairness: after voice 2 is acked, req=0101 → voice 0 is granted next (ptr=3 wraps).
- Address change after grant: change req_addr[1] from 0x0010 to 0x0020 one cycle after the grant → Addr_out stays 0x0010 for the whole fetch.
- Overrun:
  - Ticks 20 cycles apart with all four requesting and READ_LAT=1 → overrun stays 0.
  - Ticks 8 cycles apart → overrun=1 at the second tick, stays set; overrun_clr returns it to 0.
- Reset mid-fetch: assert Reset during BUSY → next cycle all outputs are 0, no ack for the aborted voice, ptr=0.
